// File: rtl/ras_ctrl.sv
// Fetch-side RAS controller: decodes calls/returns/branches into RAS strobes,
// tracks unresolved branches and re-times the RAS read into a return prediction.
module ras_ctrl #(
    parameter int WIDTH        = 32,
    parameter int MAX_BRANCHES = 16,
    parameter int CNT_W        = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [WIDTH-1:0] in_pc,
    input  logic             resolve_valid,
    input  logic             resolve_mispredict,
    output logic             ras_push,
    output logic             ras_pop,
    output logic             ras_branch,
    output logic             ras_close_valid,
    output logic             ras_close_invalid,
    output logic [WIDTH-1:0] ras_din,
    input  logic [WIDTH-1:0] ras_dout,
    input  logic             ras_empty,
    output logic             pred_valid,
    output logic [WIDTH-1:0] pred_target,
    output logic [WIDTH-1:0] pred_pc,
    output logic             pred_miss,
    output logic [CNT_W-1:0] outstanding,
    output logic             err
);

    localparam logic [6:0]       OP_COND = 7'b1100011;
    localparam logic [6:0]       OP_JAL  = 7'b1101111;
    localparam logic [6:0]       OP_JALR = 7'b1100111;
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(MAX_BRANCHES + 1);

    logic [6:0]       opcode;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic             rd_link;
    logic             rs1_link;
    logic             dec_push;
    logic             dec_pop;
    logic             dec_branch;
    logic             flush;
    logic             fire;
    logic             close_ok;
    logic             err_set;
    logic             p1;
    logic [CNT_W-1:0] cnt_next;
    logic             unused_instr;

    assign opcode       = in_instr[6:0];
    assign rd           = in_instr[11:7];
    assign rs1          = in_instr[19:15];
    assign unused_instr = ^{in_instr[31:20], in_instr[14:12]};
    assign rd_link      = (rd == 5'd1) || (rd == 5'd5);
    assign rs1_link     = (rs1 == 5'd1) || (rs1 == 5'd5);

    always_comb begin
        dec_push   = 1'b0;
        dec_pop    = 1'b0;
        dec_branch = 1'b0;
        case (opcode)
            OP_JAL:  dec_push = rd_link;
            OP_JALR: begin
                if (rd_link && !rs1_link) begin
                    dec_push = 1'b1;
                end else if (!rd_link && rs1_link) begin
                    dec_pop = 1'b1;
                end else if (rd_link && rs1_link) begin
                    dec_push = 1'b1;
                    dec_pop  = (rd != rs1);
                end
            end
            OP_COND: dec_branch = 1'b1;
            default: ;
        endcase
    end

    assign flush    = resolve_valid && resolve_mispredict;
    assign in_ready = !flush && !(dec_branch && (outstanding == FULL));
    assign fire     = in_valid && in_ready;
    assign close_ok = resolve_valid && !resolve_mispredict && (outstanding != '0);
    assign err_set  = resolve_valid && !resolve_mispredict && (outstanding == '0);

    // Strobes are forced low while reset is held, independent of the inputs.
    assign ras_push          = fire && dec_push && !reset;
    assign ras_pop           = fire && dec_pop && !reset;
    assign ras_branch        = fire && dec_branch && !reset;
    assign ras_close_valid   = close_ok && !reset;
    assign ras_close_invalid = flush && !reset;
    assign ras_din           = in_pc + WIDTH'(4);

    always_comb begin
        cnt_next = outstanding;
        if (flush) begin
            cnt_next = '0;
        end else if ((fire && dec_branch) && !close_ok) begin
            cnt_next = outstanding + CNT_W'(1);
        end else if (close_ok && !(fire && dec_branch)) begin
            cnt_next = outstanding - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
            err         <= 1'b0;
            p1          <= 1'b0;
            pred_pc     <= '0;
            pred_miss   <= 1'b0;
        end else begin
            outstanding <= cnt_next;
            if (err_set) begin
                err <= 1'b1;
            end
            p1 <= fire && dec_pop;
            if (fire && dec_pop) begin
                pred_pc   <= in_pc;
                pred_miss <= ras_empty;
            end
        end
    end

    // RAS read is registered inside the RAS, so its dout lines up with p1.
    assign pred_valid  = p1 && !flush;
    assign pred_target = ras_dout;

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed plus randomized bench for ras_ctrl against a cycle-level reference model.
module tb_ras_ctrl;

    localparam int WIDTH = 32;
    localparam int MAXB  = 16;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_instr = '0;
    logic [WIDTH-1:0] in_pc = '0;
    logic             resolve_valid = 1'b0;
    logic             resolve_mispredict = 1'b0;
    logic             ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid;
    logic [WIDTH-1:0] ras_din;
    logic [WIDTH-1:0] ras_dout = '0;
    logic             ras_empty = 1'b0;
    logic             pred_valid;
    logic [WIDTH-1:0] pred_target, pred_pc;
    logic             pred_miss;
    logic [CNT_W-1:0] outstanding;
    logic             err;

    ras_ctrl #(.WIDTH(WIDTH), .MAX_BRANCHES(MAXB), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .resolve_valid(resolve_valid), .resolve_mispredict(resolve_mispredict),
        .ras_push(ras_push), .ras_pop(ras_pop), .ras_branch(ras_branch),
        .ras_close_valid(ras_close_valid), .ras_close_invalid(ras_close_invalid),
        .ras_din(ras_din), .ras_dout(ras_dout), .ras_empty(ras_empty),
        .pred_valid(pred_valid), .pred_target(pred_target), .pred_pc(pred_pc),
        .pred_miss(pred_miss), .outstanding(outstanding), .err(err)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state
    int          m_out;
    bit          m_err;
    bit          m_p1;
    bit          m_pmiss;
    logic [31:0] m_ppc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    function automatic logic [31:0] jal(input logic [4:0] rd);
        return {20'h0, rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] jalr(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'h0, rs1, 3'b000, rd, 7'b1100111};
    endfunction

    function automatic logic [31:0] bcond();
        return {7'h0, 5'd2, 5'd3, 3'b000, 5'd0, 7'b1100011};
    endfunction

    function automatic logic [4:0] rand_reg();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd1;
            2:       return 5'd5;
            default: return 5'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        int unsigned k;
        k = $urandom_range(0, 9);
        if (k <= 3) return bcond();
        if (k <= 5) return jal(rand_reg());
        if (k <= 8) return jalr(rand_reg(), rand_reg());
        return $urandom;
    endfunction

    task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                        input bit rv, input bit rm, input logic [31:0] dout, input bit empty);
        bit          is_cond, is_jal, is_jalr, e_push, e_pop, flush, ready, fire, e_cv, e_pv;
        logic [4:0]  rd, rs1;
        @(negedge clk);
        in_valid = v; in_instr = ins; in_pc = pc;
        resolve_valid = rv; resolve_mispredict = rm;
        ras_dout = dout; ras_empty = empty;
        #1;
        rd      = ins[11:7];
        rs1     = ins[19:15];
        is_cond = (ins[6:0] == 7'b1100011);
        is_jal  = (ins[6:0] == 7'b1101111);
        is_jalr = (ins[6:0] == 7'b1100111);
        e_push  = (is_jal && is_link(rd)) || (is_jalr && is_link(rd));
        e_pop   = is_jalr && is_link(rs1) && (!is_link(rd) || rd != rs1);
        flush   = rv && rm;
        ready   = !flush && !(is_cond && m_out == MAXB + 1);
        fire    = v && ready;
        e_cv    = rv && !rm && m_out != 0;
        e_pv    = m_p1 && !flush;

        check("in_ready", 32'(in_ready), 32'(ready));
        check("push", 32'(ras_push), 32'(fire && e_push));
        check("pop", 32'(ras_pop), 32'(fire && e_pop));
        check("branch", 32'(ras_branch), 32'(fire && is_cond));
        check("close_valid", 32'(ras_close_valid), 32'(e_cv));
        check("close_invalid", 32'(ras_close_invalid), 32'(flush));
        check("din", ras_din, pc + 32'd4);
        check("outstanding", 32'(outstanding), 32'(m_out));
        check("err", 32'(err), 32'(m_err));
        check("pred_valid", 32'(pred_valid), 32'(e_pv));
        if (e_pv) begin
            check("pred_target", pred_target, dout);
            check("pred_pc", pred_pc, m_ppc);
            check("pred_miss", 32'(pred_miss), 32'(m_pmiss));
        end

        if (rv && !rm && m_out == 0) m_err = 1'b1;
        if (flush) m_out = 0;
        else m_out = m_out + int'(fire && is_cond) - int'(e_cv);
        m_p1 = fire && e_pop;
        if (m_p1) begin
            m_ppc   = pc;
            m_pmiss = empty;
        end
    endtask

    task automatic idle(input logic [31:0] dout);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, dout, 1'b0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        in_valid = 1'b1; in_instr = jalr(5'd1, 5'd5); in_pc = 32'h40;
        resolve_valid = 1'b1; resolve_mispredict = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_push", 32'(ras_push), 32'd0);
        check("rst_pop", 32'(ras_pop), 32'd0);
        check("rst_branch", 32'(ras_branch), 32'd0);
        check("rst_close_valid", 32'(ras_close_valid), 32'd0);
        check("rst_close_invalid", 32'(ras_close_invalid), 32'd0);
        check("rst_outstanding", 32'(outstanding), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_pred_valid", 32'(pred_valid), 32'd0);
        check("rst_pred_pc", pred_pc, 32'd0);
        check("rst_pred_miss", 32'(pred_miss), 32'd0);
        m_out = 0; m_err = 1'b0; m_p1 = 1'b0; m_pmiss = 1'b0; m_ppc = '0;
        @(negedge clk);
        in_valid = 1'b0; resolve_valid = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        reset_dut();

        // Mid-operation reset with three branches outstanding and a pop in flight
        repeat (3) step(1'b1, bcond(), 32'h10, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, jalr(5'd0, 5'd1), 32'h20, 1'b0, 1'b0, 32'h0, 1'b0);
        reset_dut();
        idle(32'h0);

        // Call then return, prediction one cycle later
        step(1'b1, jal(5'd1), 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, jalr(5'd0, 5'd1), 32'h200, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(32'h104);
        // Return with empty RAS, then coroutine swap
        step(1'b1, jalr(5'd0, 5'd1), 32'h300, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, jalr(5'd5, 5'd1), 32'h304, 1'b0, 1'b0, 32'hdead, 1'b0);
        step(1'b1, jalr(5'd0, 5'd5), 32'h308, 1'b0, 1'b0, 32'h0abc, 1'b0);
        idle(32'h1234);
        step(1'b1, jal(5'd5), 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0);

        // Fill the branch list, hold the extra COND, let a JAL through
        repeat (17) step(1'b1, bcond(), 32'h400, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, bcond(), 32'h444, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, jal(5'd1), 32'h448, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, bcond(), 32'h44c, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, bcond(), 32'h44c, 1'b0, 1'b0, 32'h0, 1'b0);

        // Mispredict flush squashing a pending prediction
        reset_dut();
        repeat (4) step(1'b1, bcond(), 32'h500, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, jalr(5'd0, 5'd1), 32'h510, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, jal(5'd1), 32'h514, 1'b1, 1'b1, 32'h777, 1'b0);
        idle(32'h0);

        // Spurious resolve sets sticky err; COND plus close keeps the count
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        repeat (2) step(1'b1, bcond(), 32'h600, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, bcond(), 32'h608, 1'b1, 1'b0, 32'h0, 1'b0);
        idle(32'h0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset_dut();
            end else begin
                step($urandom_range(0, 3) != 0, rand_instr(), $urandom & 32'hFFFF_FFFC,
                     $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                     $urandom, $urandom_range(0, 3) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
